// File: rtl/vc_credit_tx.sv
// Transmit side of the VC link: round-robin arbiter with per-VC credits.
// Optional sticky overflow flag: define VC_TX_CREDIT_CHECK_EN.
module vc_credit_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VC     = 4,
  parameter int VC_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_VC*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_VC-1:0]            src_valid,
  output logic [NUM_VC-1:0]            src_ready,
  input  logic                         link_en,
  output logic [DATA_WIDTH-1:0]        link_data,
  output logic [1:0]                   link_vc,
  output logic                         link_valid,
  input  logic                         credit_valid,
  input  logic [1:0]                   credit_vc,
  output logic [NUM_VC-1:0]            credit_avail,
  output logic                         credit_err
);

  localparam int VW = 2;
  localparam int CW = $clog2(VC_DEPTH + 1);

  logic [CW-1:0]     credit [NUM_VC];
  logic [VW-1:0]     ptr;
  logic [VW-1:0]     grant;
  logic [VW-1:0]     idx;
  logic              grant_vld;
  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] send_vec;
  logic [NUM_VC-1:0] ret_vec;

  always_comb begin
    credit_avail = '0;
    elig         = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      credit_avail[i] = (credit[i] != '0);
      elig[i] = src_valid[i] && credit_avail[i] && link_en;
    end
  end

  // Scan from the pointer upward; 2-bit index wraps naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = ptr + VW'(k);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    src_ready = '0;
    send_vec  = '0;
    ret_vec   = '0;
    if (grant_vld) begin
      src_ready[grant] = 1'b1;
      send_vec[grant]  = 1'b1;
    end
    if (credit_valid) ret_vec[credit_vc] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_data  <= '0;
      link_vc    <= '0;
      link_valid <= 1'b0;
      ptr        <= '0;
    end else begin
      link_valid <= grant_vld;
      if (grant_vld) begin
        link_data <= src_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        link_vc   <= grant;
        ptr       <= grant + VW'(1);
      end
    end
  end

  // Send and return on the same VC cancel; returns saturate at VC_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++)
        credit[i] <= CW'(VC_DEPTH);
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        unique case ({send_vec[i], ret_vec[i]})
          2'b10: credit[i] <= credit[i] - CW'(1);
          2'b01: begin
            if (credit[i] != CW'(VC_DEPTH))
              credit[i] <= credit[i] + CW'(1);
          end
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

`ifdef VC_TX_CREDIT_CHECK_EN
  logic [NUM_VC-1:0] full;

  always_comb begin
    full = '0;
    for (int i = 0; i < NUM_VC; i++)
      full[i] = (credit[i] == CW'(VC_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      credit_err <= 1'b0;
    else if (|(ret_vec & ~send_vec & full))
      credit_err <= 1'b1;
  end
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_tx.sv
// Directed bench for vc_credit_tx: arbitration, credits, link timing.
module tb_vc_credit_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic         link_en;
  logic [31:0]  link_data;
  logic [1:0]   link_vc;
  logic         link_valid;
  logic         credit_valid;
  logic [1:0]   credit_vc;
  logic [3:0]   credit_avail;
  logic         credit_err;

  int errs = 0;
  int checks = 0;
  logic exp_err;

  vc_credit_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .link_en      (link_en),
    .link_data    (link_data),
    .link_vc      (link_vc),
    .link_valid   (link_valid),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    src_valid    = '0;
    link_en      = 1'b1;
    credit_valid = 1'b0;
    credit_vc    = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef VC_TX_CREDIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    src_data = {32'hA5A5_0003, 32'hA5A5_0002,
                32'hA5A5_0001, 32'hA5A5_0000};

    // reset state
    do_reset();
    #1;
    chk("rst_valid", 32'(link_valid), 32'd0);
    chk("rst_avail", 32'(credit_avail), 32'hF);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_data", link_data, 32'd0);

    // VC2 alone drains its 8 credits
    src_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("vc2_ready", 32'(src_ready), 32'h4);
      tick();
      chk("vc2_valid", 32'(link_valid), 32'd1);
      chk("vc2_vc", 32'(link_vc), 32'd2);
      chk("vc2_data", link_data, 32'hA5A5_0002);
    end
    #1;
    chk("vc2_empty_ready", 32'(src_ready), 32'd0);
    chk("vc2_empty_avail", 32'(credit_avail), 32'hB);
    tick();
    chk("vc2_idle_valid", 32'(link_valid), 32'd0);
    chk("vc2_hold_data", link_data, 32'hA5A5_0002);
    chk("vc2_hold_vc", 32'(link_vc), 32'd2);

    // link_en low blocks grants
    src_valid = 4'b1011;
    link_en   = 1'b0;
    #1;
    chk("en0_ready", 32'(src_ready), 32'd0);
    tick();
    chk("en0_valid", 32'(link_valid), 32'd0);

    // round-robin with credits returned one cycle later
    do_reset();
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      credit_valid = (k > 0);
      credit_vc    = 2'((k + 3) % 4);
      #1;
      chk("rr_ready", 32'(src_ready), 32'(1 << (k % 4)));
      tick();
      chk("rr_valid", 32'(link_valid), 32'd1);
      chk("rr_vc", 32'(link_vc), 32'(k % 4));
      chk("rr_data", link_data, 32'hA5A5_0000 + 32'(k % 4));
    end
    src_valid    = 4'b0000;
    credit_valid = 1'b1;
    credit_vc    = 2'd3;
    tick();
    credit_valid = 1'b0;
    chk("rr_avail", 32'(credit_avail), 32'hF);
    chk("rr_err", 32'(credit_err), 32'd0);

    // VC1 empty: credit at t, ready at t+1, flit at t+2
    do_reset();
    src_valid = 4'b0010;
    for (int i = 0; i < 8; i++) tick();
    credit_valid = 1'b1;
    credit_vc    = 2'd1;
    #1;
    chk("z_ready_t", 32'(src_ready), 32'd0);
    chk("z_avail_t", 32'(credit_avail), 32'hD);
    tick();
    credit_valid = 1'b0;
    chk("z_valid_t1", 32'(link_valid), 32'd0);
    #1;
    chk("z_ready_t1", 32'(src_ready), 32'h2);
    tick();
    chk("z_valid_t2", 32'(link_valid), 32'd1);
    chk("z_vc_t2", 32'(link_vc), 32'd1);

    // asynchronous reset drops the in-flight flit
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(link_valid), 32'd0);
    chk("arst_avail", 32'(credit_avail), 32'hF);
    tick();
    rst_n = 1'b1;

    // VC0 at 3 credits, send and return together
    do_reset();
    src_valid = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    credit_valid = 1'b1;
    credit_vc    = 2'd0;
    #1;
    chk("sr_ready", 32'(src_ready), 32'h1);
    tick();
    credit_valid = 1'b0;
    chk("sr_valid", 32'(link_valid), 32'd1);
    chk("sr_err", 32'(credit_err), 32'd0);
    tick();
    tick();
    chk("sr_avail_1", 32'(credit_avail), 32'hF);
    tick();
    chk("sr_avail_0", 32'(credit_avail), 32'hE);
    #1;
    chk("sr_ready_0", 32'(src_ready), 32'd0);

    // credit return to a full VC3
    do_reset();
    src_valid    = 4'b0000;
    credit_valid = 1'b1;
    credit_vc    = 2'd3;
    tick();
    credit_valid = 1'b0;
    chk("ovf_err", 32'(credit_err), 32'(exp_err));
    tick();
    chk("ovf_sticky", 32'(credit_err), 32'(exp_err));
    src_valid = 4'b1000;
    for (int i = 0; i < 8; i++) tick();
    chk("ovf_sat_avail", 32'(credit_avail), 32'h7);
    #1;
    chk("ovf_sat_ready", 32'(src_ready), 32'd0);
    chk("ovf_still", 32'(credit_err), 32'(exp_err));
    rst_n = 1'b0;
    #1;
    chk("ovf_rst_err", 32'(credit_err), 32'd0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
